fq_change_accumulator: RTL and testbench

Producer side of the frequency-change read handshake used by the MCU command dispatcher. The block counts up and down events from the phase/frequency detector over a fixed sampling window. At the end of each window it folds the net count into a pending signed 8-bit snapshot. It presents that snapshot on `fq_change` with `fq_change_valid`, and consumes it when the dispatcher pulses `fq_read_enable`.

---
 rtl/fq_change_accumulator.sv | 204 ++++++++++++++++++++
 tb/tb_fq_change_accumulator.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fq_change_accumulator.sv
// -----------------------------------------------------------------------------
// fq_change_accumulator
//
// Purpose:
//   Producer side of the frequency-change read handshake. Counts up/down events
//   from the phase/frequency detector over a fixed window of WINDOW_CYCLES
//   clocks. At each window end the net count is folded into a pending signed
//   8-bit snapshot. The dispatcher consumes the snapshot with a rising edge on
//   fq_read_enable.
//
// Parameters:
//   WINDOW_CYCLES : window length in aclk cycles (>= 2)
//   ACC_WIDTH     : width of the signed in-window accumulator (>= 9)
//
// Ports:
//   aclk            in   system clock
//   reset           in   asynchronous, active-high reset
//   up_evt          in   detector "too slow" event (+1)
//   dn_evt          in   detector "too fast" event (-1)
//   fq_read_enable  in   read strobe; its rising edge consumes the snapshot
//   fq_change       out  pending snapshot, signed 8-bit, range [-127, +127]
//   fq_change_valid out  snapshot holds at least one unread window result
//   fq_overrun      out  sticky: a window merged into an unread snapshot
//
// Build option:
//   FQ_ACC_SYNC_EN : when defined, up_evt/dn_evt are asynchronous levels.
//                    Each passes a 2-FF synchronizer and a rising-edge
//                    detector, so each input rising edge counts once.
//
// Read handshake:
//   fq_change_valid acts as "valid". A rising edge of fq_read_enable acts as
//   a one-shot "ready". The reader samples fq_change in the same cycle it
//   raises fq_read_enable. The snapshot and both flags clear on the next
//   cycle, unless a window ends in that same cycle, in which case the new
//   window result is loaded fresh. Holding the strobe high consumes only once.
// -----------------------------------------------------------------------------
module fq_change_accumulator #(
    parameter int WINDOW_CYCLES = 100000,
    parameter int ACC_WIDTH     = 16
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic              up_evt,
    input  logic              dn_evt,
    input  logic              fq_read_enable,
    output logic signed [7:0] fq_change,
    output logic              fq_change_valid,
    output logic              fq_overrun
);

    localparam int CNT_W   = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int ACC_MAX = (2 ** (ACC_WIDTH - 1)) - 1;

    localparam logic [CNT_W-1:0]         L_WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic signed [ACC_WIDTH:0] L_ACC_MAX  = (ACC_WIDTH + 1)'(ACC_MAX);
    localparam logic signed [ACC_WIDTH:0] L_ACC_MIN  = -L_ACC_MAX;
    localparam logic signed [ACC_WIDTH:0] L_W_P127   = (ACC_WIDTH + 1)'(127);
    localparam logic signed [ACC_WIDTH:0] L_W_N127   = -L_W_P127;
    localparam logic signed [8:0]         L_S_P127   = 9'sd127;
    localparam logic signed [8:0]         L_S_N127   = -9'sd127;

    logic [CNT_W-1:0]            r_win_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [7:0]           r_snap;
    logic                        r_valid;
    logic                        r_overrun;
    logic                        r_rd_prev;

    logic                        w_up;
    logic                        w_dn;
    logic signed [1:0]           w_d;
    logic signed [ACC_WIDTH:0]   w_sum;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic signed [7:0]           w_wsum;
    logic signed [8:0]           w_merge;
    logic signed [7:0]           w_merge_sat;
    logic                        w_win_end;
    logic                        w_consume;

    // -------------------------------------------------------------------------
    // Event qualification
    // -------------------------------------------------------------------------
`ifdef FQ_ACC_SYNC_EN
    logic r_up_meta, r_up_sync, r_up_prev;
    logic r_dn_meta, r_dn_sync, r_dn_prev;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_up_meta <= 1'b0;
            r_up_sync <= 1'b0;
            r_up_prev <= 1'b0;
            r_dn_meta <= 1'b0;
            r_dn_sync <= 1'b0;
            r_dn_prev <= 1'b0;
        end else begin
            r_up_meta <= up_evt;
            r_up_sync <= r_up_meta;
            r_up_prev <= r_up_sync;
            r_dn_meta <= dn_evt;
            r_dn_sync <= r_dn_meta;
            r_dn_prev <= r_dn_sync;
        end
    end

    // One count per synchronized rising edge, however long the level stays high.
    assign w_up = r_up_sync & ~r_up_prev;
    assign w_dn = r_dn_sync & ~r_dn_prev;
`else
    assign w_up = up_evt;
    assign w_dn = dn_evt;
`endif

    // -------------------------------------------------------------------------
    // Datapath: event term, accumulator saturation, window sum, merge
    // -------------------------------------------------------------------------
    always_comb begin
        w_d = 2'sb00;
        if (w_up && !w_dn) begin
            w_d = 2'sb01;
        end else if (w_dn && !w_up) begin
            w_d = 2'sb11;
        end
    end

    // One guard bit so the saturation decision sees the true sum.
    assign w_sum = {r_acc[ACC_WIDTH-1], r_acc} + {{(ACC_WIDTH - 1){w_d[1]}}, w_d};

    always_comb begin
        w_acc_next = w_sum[ACC_WIDTH-1:0];
        if (w_sum > L_ACC_MAX) begin
            w_acc_next = L_ACC_MAX[ACC_WIDTH-1:0];
        end else if (w_sum < L_ACC_MIN) begin
            w_acc_next = L_ACC_MIN[ACC_WIDTH-1:0];
        end
    end

    // The window result is clamped symmetrically, so -128 never appears.
    always_comb begin
        w_wsum = w_sum[7:0];
        if (w_sum > L_W_P127) begin
            w_wsum = 8'sd127;
        end else if (w_sum < L_W_N127) begin
            w_wsum = -8'sd127;
        end
    end

    assign w_merge = {r_snap[7], r_snap} + {w_wsum[7], w_wsum};

    always_comb begin
        w_merge_sat = w_merge[7:0];
        if (w_merge > L_S_P127) begin
            w_merge_sat = 8'sd127;
        end else if (w_merge < L_S_N127) begin
            w_merge_sat = -8'sd127;
        end
    end

    assign w_win_end = (r_win_cnt == L_WIN_LAST);
    assign w_consume = fq_read_enable & ~r_rd_prev;

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_win_cnt <= '0;
            r_acc     <= '0;
            r_snap    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_rd_prev <= 1'b0;
        end else begin
            r_rd_prev <= fq_read_enable;

            if (w_win_end) begin
                r_win_cnt <= '0;
                r_acc     <= '0;
                r_valid   <= 1'b1;
                // A consume in the window-end cycle frees the snapshot, so the
                // new result is loaded fresh instead of merged.
                if (!r_valid || w_consume) begin
                    r_snap    <= w_wsum;
                    r_overrun <= 1'b0;
                end else begin
                    r_snap    <= w_merge_sat;
                    r_overrun <= 1'b1;
                end
            end else begin
                r_win_cnt <= r_win_cnt + 1'b1;
                r_acc     <= w_acc_next;
                if (w_consume) begin
                    r_snap    <= '0;
                    r_valid   <= 1'b0;
                    r_overrun <= 1'b0;
                end
            end
        end
    end

    assign fq_change       = r_snap;
    assign fq_change_valid = r_valid;
    assign fq_overrun      = r_overrun;

endmodule

// File: tb/tb_fq_change_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fq_change_accumulator
//
// Directed bench for fq_change_accumulator. The main instance uses a 16-cycle
// window. A second instance (300-cycle window, 9-bit accumulator) covers
// accumulator saturation and window-sum clamping. Inputs are driven 1 ns after
// the rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_fq_change_accumulator;

  localparam int WIN  = 16;
  localparam int WIN2 = 300;

  logic              aclk;
  logic              reset;
  logic              up_evt;
  logic              dn_evt;
  logic              fq_read_enable;
  logic signed [7:0] chg;
  logic              valid;
  logic              ovr;

  logic              up2;
  logic              dn2;
  logic              rd2;
  logic signed [7:0] chg2;
  logic              valid2;
  logic              ovr2;

  int checks;
  int errors;

  fq_change_accumulator #(
    .WINDOW_CYCLES(WIN),
    .ACC_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .reset(reset),
    .up_evt(up_evt),
    .dn_evt(dn_evt),
    .fq_read_enable(fq_read_enable),
    .fq_change(chg),
    .fq_change_valid(valid),
    .fq_overrun(ovr)
  );

  fq_change_accumulator #(
    .WINDOW_CYCLES(WIN2),
    .ACC_WIDTH(9)
  ) dut2 (
    .aclk(aclk),
    .reset(reset),
    .up_evt(up2),
    .dn_evt(dn2),
    .fq_read_enable(rd2),
    .fq_change(chg2),
    .fq_change_valid(valid2),
    .fq_overrun(ovr2)
  );

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Hold reset across one edge, then release. The next edge is window cycle 0.
  task automatic apply_reset();
    up_evt = 1'b0;
    dn_evt = 1'b0;
    fq_read_enable = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic u, input logic d, input logic r);
    up_evt = u;
    dn_evt = d;
    fq_read_enable = r;
    tick();
  endtask

  // One full window from cycle 0. Bit i of u/d drives cycle i.
  task automatic run_window(input logic [WIN-1:0] u, input logic [WIN-1:0] d);
    for (int i = 0; i < WIN; i++) begin
      cyc(u[i], d[i], 1'b0);
    end
    up_evt = 1'b0;
    dn_evt = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (chg !== 8'sd0 || valid !== 1'b0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: got chg=%0d valid=%0b ovr=%0b, exp 0/0/0", chg, valid, ovr);
    end
    // Make the outputs non-zero first, so the reset check means something.
    run_window(16'h0007, 16'h0000);
    checks++;
    if (chg !== 8'sd3 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_prewin: got chg=%0d valid=%0b, exp 3/1", chg, valid);
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
    up_evt = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (chg !== 8'sd0 || valid !== 1'b0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got chg=%0d valid=%0b ovr=%0b, exp 0/0/0", chg, valid, ovr);
    end
    tick();
    reset = 1'b0;
    run_window(16'h0300, 16'h0000);
    checks++;
    if (chg !== 8'sd2 || valid !== 1'b1 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset_postwin: got chg=%0d valid=%0b ovr=%0b, exp 2/1/0", chg, valid, ovr);
    end
  endtask

  task automatic test_basic_count();
    apply_reset();
    // 7 ups (0..6), 3 downs (8,9,11), simultaneous at cycle 10 -> +4
    run_window(16'h047F, 16'h0F00);
    checks++;
    if (chg !== 8'sd4 || valid !== 1'b1 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL basic_win: got chg=%0d valid=%0b ovr=%0b, exp 4/1/0", chg, valid, ovr);
    end
    up_evt = 1'b0;
    dn_evt = 1'b0;
    fq_read_enable = 1'b1;
    checks++;
    if (chg !== 8'sd4) begin
      errors++;
      $display("FAIL basic_sample: got %0d exp 4", chg);
    end
    tick();
    fq_read_enable = 1'b0;
    checks++;
    if (chg !== 8'sd0 || valid !== 1'b0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL basic_clear: got chg=%0d valid=%0b ovr=%0b, exp 0/0/0", chg, valid, ovr);
    end
  endtask

  task automatic test_held_strobe();
    apply_reset();
    run_window(16'h0007, 16'h0000);
    fq_read_enable = 1'b1;
    checks++;
    if (chg !== 8'sd3) begin
      errors++;
      $display("FAIL held_sample: got %0d exp 3", chg);
    end
    tick();
    checks++;
    if (chg !== 8'sd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL held_clear: got chg=%0d valid=%0b, exp 0/0", chg, valid);
    end
    // Strobe stays high through the next window end: cycles 1..15, ups at 1,2.
    for (int i = 1; i < WIN; i++) cyc(i <= 2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    checks++;
    if (chg !== 8'sd2 || valid !== 1'b1 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL held_noreconsume: got chg=%0d valid=%0b ovr=%0b, exp 2/1/0", chg, valid, ovr);
    end
    cyc(1'b0, 1'b0, 1'b0);
    fq_read_enable = 1'b1;
    checks++;
    if (chg !== 8'sd2) begin
      errors++;
      $display("FAIL held_resample: got %0d exp 2", chg);
    end
    tick();
    fq_read_enable = 1'b0;
    tick();
    // A read while nothing is pending returns 0 and changes nothing.
    fq_read_enable = 1'b1;
    checks++;
    if (chg !== 8'sd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_read_sample: got chg=%0d valid=%0b, exp 0/0", chg, valid);
    end
    tick();
    fq_read_enable = 1'b0;
    checks++;
    if (chg !== 8'sd0 || valid !== 1'b0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL empty_read_after: got chg=%0d valid=%0b ovr=%0b, exp 0/0/0", chg, valid, ovr);
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    run_window(16'h0000, 16'h001F);
    checks++;
    if (chg !== -8'sd5 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_win1: got chg=%0d ovr=%0b, exp -5/0", chg, ovr);
    end
    run_window(16'h0000, 16'h0FC0);
    checks++;
    if (chg !== -8'sd11 || valid !== 1'b1 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_merge: got chg=%0d valid=%0b ovr=%0b, exp -11/1/1", chg, valid, ovr);
    end
    fq_read_enable = 1'b1;
    checks++;
    if (chg !== -8'sd11) begin
      errors++;
      $display("FAIL ovr_sample: got %0d exp -11", chg);
    end
    tick();
    fq_read_enable = 1'b0;
    checks++;
    if (chg !== 8'sd0 || valid !== 1'b0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got chg=%0d valid=%0b ovr=%0b, exp 0/0/0", chg, valid, ovr);
    end
  endtask

  task automatic test_saturation();
    int exp_v;
    apply_reset();
    up_evt = 1'b1;
    for (int w = 1; w <= 9; w++) begin
      repeat (WIN) tick();
      exp_v = (16 * w > 127) ? 127 : 16 * w;
      checks++;
      if (int'(chg) !== exp_v) begin
        errors++;
        $display("FAIL sat_up_w%0d: got %0d exp %0d", w, chg, exp_v);
      end
    end
    up_evt = 1'b0;
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL sat_up_ovr: got %0b exp 1", ovr);
    end
    apply_reset();
    dn_evt = 1'b1;
    for (int w = 1; w <= 9; w++) begin
      repeat (WIN) tick();
      exp_v = (16 * w > 127) ? -127 : -16 * w;
      checks++;
      if (int'(chg) !== exp_v) begin
        errors++;
        $display("FAIL sat_dn_w%0d: got %0d exp %0d", w, chg, exp_v);
      end
    end
    dn_evt = 1'b0;
    // Wide window with a narrow accumulator: 300 events must clamp, not wrap.
    apply_reset();
    up2 = 1'b1;
    repeat (WIN2) tick();
    up2 = 1'b0;
    checks++;
    if (chg2 !== 8'sd127 || valid2 !== 1'b1 || ovr2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_wide_up: got chg=%0d valid=%0b ovr=%0b, exp 127/1/0", chg2, valid2, ovr2);
    end
    apply_reset();
    dn2 = 1'b1;
    repeat (WIN2) tick();
    dn2 = 1'b0;
    checks++;
    if (chg2 !== -8'sd127 || valid2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_wide_dn: got chg=%0d valid=%0b, exp -127/1", chg2, valid2);
    end
  endtask

  task automatic test_coincident_read();
    apply_reset();
    run_window(16'h0001, 16'h0000);
    run_window(16'h0001, 16'h0000);
    checks++;
    if (chg !== 8'sd2 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL coin_pending: got chg=%0d ovr=%0b, exp 2/1", chg, ovr);
    end
    for (int i = 0; i < WIN - 1; i++) cyc(i < 9, 1'b0, 1'b0);
    up_evt = 1'b0;
    fq_read_enable = 1'b1;
    checks++;
    if (chg !== 8'sd2) begin
      errors++;
      $display("FAIL coin_sample: got %0d exp 2", chg);
    end
    tick();
    fq_read_enable = 1'b0;
    checks++;
    if (chg !== 8'sd9 || valid !== 1'b1 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL coin_load: got chg=%0d valid=%0b ovr=%0b, exp 9/1/0", chg, valid, ovr);
    end
  endtask

  task automatic test_sync();
    logic u;
    apply_reset();
    checks++;
    if (chg !== 8'sd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL sync_reset: got chg=%0d valid=%0b, exp 0/0", chg, valid);
    end
    // Pulses at cycles 0 and 2, then a 40-cycle level from cycle 4.
    for (int i = 0; i < 3 * WIN; i++) begin
      u = (i == 0) || (i == 2) || (i >= 4 && i < 44);
      cyc(u, 1'b0, 1'b0);
      if (i % WIN == WIN - 1) begin
        checks++;
        if (chg !== 8'sd3 || valid !== 1'b1) begin
          errors++;
          $display("FAIL sync_win%0d: got chg=%0d valid=%0b, exp 3/1", i / WIN, chg, valid);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    up_evt = 1'b0;
    dn_evt = 1'b0;
    fq_read_enable = 1'b0;
    up2 = 1'b0;
    dn2 = 1'b0;
    rd2 = 1'b0;
    #12;
`ifdef FQ_ACC_SYNC_EN
    test_sync();
`else
    test_reset();
    test_basic_count();
    test_held_strobe();
    test_overrun();
    test_saturation();
    test_coincident_read();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
